// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// -------------
// Command arbiter and SDRAM bus multiplexer for the SDRAM controller.
// The initialisation sequencer owns the bus until init_end rises. After that,
// the bus is granted to one of three channels: auto-refresh, write burst or
// read burst. Refresh always has the highest priority. The running channel is
// never preempted. Every grant passes through ARBIT for at least one cycle.
//
// Configuration macro: ARB_RR_EN
//   defined   - write and read alternate when both request in the same ARBIT
//               cycle (1-bit last-served register).
//   undefined - fixed priority, write before read.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   init_end                         init sequence finished (level)
//   init_cmd, init_addr              init sequencer command/address
//   ref_req, wr_req, rd_req          channel requests, held until granted
//   ref_end, wr_end, rd_end          one-cycle "channel finished" pulses
//   ref/wr/rd_cmd, ref/wr/rd_addr    channel commands and addresses
//   wr_bank, rd_bank                 channel bank addresses
//   ref_en, wr_en, rd_en             one-cycle registered grant pulses
//   sdram_cmd, sdram_addr, sdram_bank muxed SDRAM pin values
//   arb_state                        one-hot current state (debug)
module sdram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int BANK_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              ref_end,
    input  logic              wr_end,
    input  logic              rd_end,
    input  logic [3:0]        ref_cmd,
    input  logic [3:0]        wr_cmd,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [4:0]        arb_state
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ARBIT = 5'b00010,
        AREF  = 5'b00100,
        WRITE = 5'b01000,
        READ  = 5'b10000
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    state_t state_q, state_d;
    logic   enter;
    logic   wrWins;

`ifdef ARB_RR_EN
    // rdTurn_q is high when the last data transfer was a write, so read goes
    // next if both channels request together.
    logic rdTurn_q;
    assign wrWins = wr_req && !(rd_req && rdTurn_q);
`else
    assign wrWins = wr_req;
`endif

    // Next-state selection. Refresh wins outright in ARBIT. The data channels
    // then compete through wrWins. A busy channel holds the bus until its
    // own end pulse, so stray ends from other channels are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init_end) state_d = ARBIT;
            ARBIT: begin
                if (ref_req)      state_d = AREF;
                else if (wrWins)  state_d = WRITE;
                else if (rd_req)  state_d = READ;
            end
            AREF:    if (ref_end) state_d = ARBIT;
            WRITE:   if (wr_end)  state_d = ARBIT;
            READ:    if (rd_end)  state_d = ARBIT;
            default: state_d = IDLE;
        endcase
    end

    // High on the edge that moves into a new state. The grant pulses are
    // taken from this flag, so each pulse covers only the first cycle
    // spent in the channel state.
    assign enter = (state_d != state_q);

    // State register and registered grant pulses. The reset is asynchronous,
    // so a reset during a burst drops the grants and returns the bus to
    // init at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ref_en   <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
`ifdef ARB_RR_EN
            rdTurn_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ref_en  <= enter && (state_d == AREF);
            wr_en   <= enter && (state_d == WRITE);
            rd_en   <= enter && (state_d == READ);
`ifdef ARB_RR_EN
            if (enter && (state_d == WRITE))     rdTurn_q <= 1'b1;
            else if (enter && (state_d == READ)) rdTurn_q <= 1'b0;
`endif
        end
    end

    // Pin multiplexer, decoded directly from the current state. ARBIT and any
    // corrupted encoding drive NOP, so the pins are always quiet between
    // owners.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state_q)
            IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

    assign arb_state = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// ----------------
// Self-checking bench for sdram_arbiter. A directed opening covers reset, the
// init handover, simultaneous requests and a stray end pulse. Random traffic
// with asynchronous resets follows. Outputs are compared each cycle with a
// behavioural model of bus ownership. Follows ARB_RR_EN like the design.
module tb_sdram_arbiter;

    localparam int AW = 12;
    localparam int BW = 2;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Model owner codes
    localparam int M_IDLE = 0;
    localparam int M_ARB  = 1;
    localparam int M_REF  = 2;
    localparam int M_WR   = 3;
    localparam int M_RD   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_end;
    logic [3:0]    init_cmd;
    logic [AW-1:0] init_addr;
    logic          ref_req, wr_req, rd_req;
    logic          ref_end, wr_end, rd_end;
    logic [3:0]    ref_cmd, wr_cmd, rd_cmd;
    logic [AW-1:0] ref_addr, wr_addr, rd_addr;
    logic [BW-1:0] wr_bank, rd_bank;
    logic          ref_en, wr_en, rd_en;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_bank;
    logic [4:0]    arb_state;

    sdram_arbiter #(.ADDR_W(AW), .BANK_W(BW)) dut (
        .clk(clk), .rst(rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .wr_req(wr_req), .rd_req(rd_req),
        .ref_end(ref_end), .wr_end(wr_end), .rd_end(rd_end),
        .ref_cmd(ref_cmd), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
        .ref_addr(ref_addr), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .wr_bank(wr_bank), .rd_bank(rd_bank),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .sdram_bank(sdram_bank), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    int checksDone   = 0;
    int checksPassed = 0;

    // Model state: current bus owner, grants expected this cycle, and
    // whether the last data transfer was a write.
    int mode;
    bit expRef, expWr, expRd;
    bit lastWasWrite;

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksDone++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    function automatic void modelReset();
        mode         = M_IDLE;
        expRef       = 1'b0;
        expWr        = 1'b0;
        expRd        = 1'b0;
        lastWasWrite = 1'b0;
    endfunction

    // Applies the ownership rules for one clock edge, using the inputs
    // sampled at that edge.
    function automatic void modelStep();
        int nxt = mode;
        expRef = 1'b0;
        expWr  = 1'b0;
        expRd  = 1'b0;
        case (mode)
            M_IDLE: if (init_end) nxt = M_ARB;
            M_ARB: begin
                if (ref_req) nxt = M_REF;
                else if (wr_req && rd_req) nxt = (RR && lastWasWrite) ? M_RD : M_WR;
                else if (wr_req) nxt = M_WR;
                else if (rd_req) nxt = M_RD;
            end
            M_REF: if (ref_end) nxt = M_ARB;
            M_WR:  if (wr_end)  nxt = M_ARB;
            M_RD:  if (rd_end)  nxt = M_ARB;
            default: nxt = M_IDLE;
        endcase
        if (mode == M_ARB && nxt != M_ARB) begin
            expRef = (nxt == M_REF);
            expWr  = (nxt == M_WR);
            expRd  = (nxt == M_RD);
            if (nxt == M_WR) lastWasWrite = 1'b1;
            if (nxt == M_RD) lastWasWrite = 1'b0;
        end
        mode = nxt;
    endfunction

    // Compares every output with what the current owner should put on the bus.
    task automatic checkAll();
        logic [3:0]    eCmd;
        logic [AW-1:0] eAddr;
        logic [BW-1:0] eBank;
        eCmd  = 4'b0111;
        eAddr = '0;
        eBank = '0;
        case (mode)
            M_IDLE: begin eCmd = init_cmd; eAddr = init_addr; end
            M_REF:  begin eCmd = ref_cmd;  eAddr = ref_addr;  end
            M_WR:   begin eCmd = wr_cmd;   eAddr = wr_addr; eBank = wr_bank; end
            M_RD:   begin eCmd = rd_cmd;   eAddr = rd_addr; eBank = rd_bank; end
            default: ;
        endcase
        checkOutput("arb_state",  32'(arb_state),  32'(1) << mode);
        checkOutput("ref_en",     32'(ref_en),     32'(expRef));
        checkOutput("wr_en",      32'(wr_en),      32'(expWr));
        checkOutput("rd_en",      32'(rd_en),      32'(expRd));
        checkOutput("sdram_cmd",  32'(sdram_cmd),  32'(eCmd));
        checkOutput("sdram_addr", 32'(sdram_addr), 32'(eAddr));
        checkOutput("sdram_bank", 32'(sdram_bank), 32'(eBank));
    endtask

    // Advances one clock. The model follows the same edge. Checking happens
    // on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) modelReset();
        else     modelStep();
        @(negedge clk);
        checkAll();
    endtask

    // Randomises all inputs for the next cycle.
    task automatic applyStimulus();
        init_end  = ($urandom_range(0, 7) != 0);
        ref_req   = ($urandom_range(0, 3) == 0);
        wr_req    = ($urandom_range(0, 1) == 0);
        rd_req    = ($urandom_range(0, 1) == 0);
        ref_end   = ($urandom_range(0, 3) == 0);
        wr_end    = ($urandom_range(0, 3) == 0);
        rd_end    = ($urandom_range(0, 3) == 0);
        init_cmd  = 4'($urandom);
        ref_cmd   = 4'($urandom);
        wr_cmd    = 4'($urandom);
        rd_cmd    = 4'($urandom);
        init_addr = AW'($urandom);
        ref_addr  = AW'($urandom);
        wr_addr   = AW'($urandom);
        rd_addr   = AW'($urandom);
        wr_bank   = BW'($urandom);
        rd_bank   = BW'($urandom);
    endtask

    // Applies reset away from the clock edge and checks the outputs before
    // the next edge arrives.
    task automatic asyncReset();
        #2 rst = 1'b1;
        #1 modelReset();
        checkAll();
    endtask

    initial begin
        bit didRdReset = 1'b0;
        rst = 1'b1;
        applyStimulus();
        init_end = 1'b0; ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        init_cmd = 4'b0010;
        modelReset();
        #12 checkAll();
        @(negedge clk) rst = 1'b0;

        // Init still running: the bus stays with init.
        repeat (10) step();
        init_end = 1'b1;
        step();

        // All three channels request together: refresh first, then write, then read.
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        ref_req = 1'b0;
        step();
        ref_end = 1'b1;
        step();
        ref_end = 1'b0;
        step();
        wr_req = 1'b0; wr_addr = 12'hABC; wr_bank = 2'b10;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        repeat (2) step();
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        step();
        rd_req = 1'b0;
        repeat (2) step();
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        step();

        // Random traffic, with asynchronous resets in READ and at a fixed point.
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            if ((!didRdReset && i > 500 && mode == M_RD) || i == 2000) begin
                if (mode == M_RD) didRdReset = 1'b1;
                asyncReset();
            end
            applyStimulus();
            step();
        end

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
